// File: rtl/vscale_hazard_unit_pkg.sv
// rtl/vscale_hazard_unit_pkg.sv - shared constants and types for the vscale hazard unit
package vscale_hazard_unit_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int STAGES_DEFAULT      = 2;
  localparam int MAX_PENDING_DEFAULT = 2;

  // Bypass select encoding: 0 = regfile, k + STAGE_OFFSET = stage k, STAGES + LL_OFFSET = ll response
  localparam int BYPASS_SEL_REGFILE   = 0;
  localparam int BYPASS_SEL_STAGE_OFS = 0;
  localparam int BYPASS_SEL_LL_OFS    = 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
  } stage_t;

endpackage

// File: rtl/vscale_hazard_unit_if.sv
// rtl/vscale_hazard_unit_if.sv - DX/long-latency handshake between pipeline control and hazard unit
interface vscale_hazard_unit_if
  import vscale_hazard_unit_pkg::*;
#(
  parameter int STAGES      = STAGES_DEFAULT,
  parameter int MAX_PENDING = MAX_PENDING_DEFAULT,
  parameter int SEL_W       = $clog2(STAGES + 2),
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
);

  logic                  dx_valid;
  logic [REG_ADDR_W-1:0] dx_rs1_addr;
  logic [REG_ADDR_W-1:0] dx_rs2_addr;
  logic                  dx_uses_rs1;
  logic                  dx_uses_rs2;
  logic [REG_ADDR_W-1:0] dx_rd_addr;
  logic                  dx_wr_reg;
  logic                  dx_long;
  logic                  pipe_advance;
  logic                  flush;
  logic                  ll_resp_valid;

  logic                  issue;
  logic                  stall_DX;
  logic [SEL_W-1:0]      bypass_sel_rs1;
  logic [SEL_W-1:0]      bypass_sel_rs2;
  logic [REG_ADDR_W-1:0] ll_resp_rd;
  logic [CNT_W-1:0]      pending_count;
  logic                  ll_underflow;

  modport master (
    output dx_valid, dx_rs1_addr, dx_rs2_addr, dx_uses_rs1, dx_uses_rs2,
           dx_rd_addr, dx_wr_reg, dx_long, pipe_advance, flush, ll_resp_valid,
    input  issue, stall_DX, bypass_sel_rs1, bypass_sel_rs2, ll_resp_rd,
           pending_count, ll_underflow
  );

  modport slave (
    input  dx_valid, dx_rs1_addr, dx_rs2_addr, dx_uses_rs1, dx_uses_rs2,
           dx_rd_addr, dx_wr_reg, dx_long, pipe_advance, flush, ll_resp_valid,
    output issue, stall_DX, bypass_sel_rs1, bypass_sel_rs2, ll_resp_rd,
           pending_count, ll_underflow
  );

endinterface

// File: rtl/vscale_rd_fifo.sv
// rtl/vscale_rd_fifo.sv - in-order destination-tag FIFO for outstanding long-latency ops
module vscale_rd_fifo
  import vscale_hazard_unit_pkg::*;
#(
  parameter int DEPTH = MAX_PENDING_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [REG_ADDR_W-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vscale_hazard_unit.sv
// rtl/vscale_hazard_unit.sv - DX issue/stall, operand bypass and long-op scoreboard for vscale
module vscale_hazard_unit
  import vscale_hazard_unit_pkg::*;
#(
  parameter int STAGES      = STAGES_DEFAULT,
  parameter int MAX_PENDING = MAX_PENDING_DEFAULT,
  parameter int SEL_W       = $clog2(STAGES + 2),
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input logic                 clk,
  input logic                 reset,
  vscale_hazard_unit_if.slave hz
);

  stage_t                stage_q [1:STAGES];
  logic [31:0]           sb_q, sb_d;
  logic                  underflow_q;

  logic [REG_ADDR_W-1:0] ll_head;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  ll_pop;
  logic                  raw1, raw2, waw, full_stall, hazard, issue_raw;

  vscale_rd_fifo #(
    .DEPTH (MAX_PENDING),
    .CNT_W (CNT_W)
  ) u_rd_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (issue_raw && hz.dx_long),
    .push_data_i (hz.dx_rd_addr),
    .pop_i       (hz.ll_resp_valid),
    .head_o      (ll_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign ll_pop = hz.ll_resp_valid && !fifo_empty;

  // The completing op's result is on the response bus this cycle, so it no longer blocks readers
  function automatic logic raw_pend(input logic uses, input logic [REG_ADDR_W-1:0] rs);
    return uses && (rs != '0) && sb_q[rs] && !(ll_pop && (ll_head == rs));
  endfunction

  function automatic logic [SEL_W-1:0] bypass_for(input logic uses,
                                                  input logic [REG_ADDR_W-1:0] rs);
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(BYPASS_SEL_REGFILE);
    if (uses && (rs != '0)) begin
      for (int k = STAGES; k >= 1; k--) begin
        if (stage_q[k].valid && stage_q[k].wr && (stage_q[k].rd == rs))
          sel = SEL_W'(k + BYPASS_SEL_STAGE_OFS);
      end
      if (ll_pop && (ll_head == rs)) sel = SEL_W'(STAGES + BYPASS_SEL_LL_OFS);
    end
    return sel;
  endfunction

  assign raw1       = raw_pend(hz.dx_uses_rs1, hz.dx_rs1_addr);
  assign raw2       = raw_pend(hz.dx_uses_rs2, hz.dx_rs2_addr);
  assign waw        = hz.dx_wr_reg && (hz.dx_rd_addr != '0) && sb_q[hz.dx_rd_addr];
  assign full_stall = hz.dx_long && fifo_full && !hz.ll_resp_valid;
  assign hazard     = hz.dx_valid && (raw1 || raw2 || waw || full_stall);
  assign issue_raw  = hz.dx_valid && !hz.flush && !hazard && hz.pipe_advance;

  assign hz.issue          = issue_raw && !reset;
  assign hz.stall_DX       = !hz.flush && (hazard || !hz.pipe_advance);
  assign hz.bypass_sel_rs1 = reset ? '0 : bypass_for(hz.dx_uses_rs1, hz.dx_rs1_addr);
  assign hz.bypass_sel_rs2 = reset ? '0 : bypass_for(hz.dx_uses_rs2, hz.dx_rs2_addr);
  assign hz.ll_resp_rd     = ll_head;
  assign hz.pending_count  = fifo_count;
  assign hz.ll_underflow   = underflow_q;

  always_comb begin
    sb_d = sb_q;
    if (ll_pop) sb_d[ll_head] = 1'b0;
    if (issue_raw && hz.dx_long && hz.dx_wr_reg && (hz.dx_rd_addr != '0))
      sb_d[hz.dx_rd_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q        <= '0;
      underflow_q <= 1'b0;
    end else begin
      sb_q        <= sb_d;
      underflow_q <= hz.ll_resp_valid && fifo_empty;
    end
  end

  // Long-op results come back through the response bus, never through the stage bypass
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) stage_q[k] <= '0;
    end else if (hz.pipe_advance) begin
      stage_q[1] <= issue_raw
                    ? '{valid: 1'b1, rd: hz.dx_rd_addr,
                        wr: hz.dx_wr_reg && !hz.dx_long && (hz.dx_rd_addr != '0)}
                    : '0;
      for (int k = 2; k <= STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

endmodule
